// File: rtl/rx_block_sync.sv
// rx_block_sync
//   Receive-side 66b block lock state machine for the 64b/66b PCS.
//   Checks the 2-bit sync header of each candidate block from the receive
//   gearbox, declares lock after SH_CNT_MAX consecutive good headers, drops
//   lock when SH_INV_MAX invalid headers land in one window, and requests
//   single-bit slips (followed by SLIP_WAIT discarded headers) until the
//   block boundary is found.
//
// Ports
//   clk     in  1  single clock, posedge
//   nreset  in  1  asynchronous active-low reset
//   valid_i in  1  head_i carries a new candidate header this cycle
//   head_i  in  2  candidate sync header (valid iff 2'b01 or 2'b10)
//   slip_o  out 1  one-cycle registered pulse: shift boundary by one bit
//   lock_o  out 1  registered block-lock indication
module rx_block_sync #(
  parameter int SH_CNT_MAX = 64,
  parameter int SH_INV_MAX = 16,
  parameter int SLIP_WAIT  = 2
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       valid_i,
  input  logic [1:0] head_i,
  output logic       slip_o,
  output logic       lock_o
);

  localparam int SH_W   = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W  = $clog2(SH_INV_MAX + 1);
  localparam int WAIT_W = (SLIP_WAIT > 0) ? $clog2(SLIP_WAIT + 1) : 1;

  typedef enum logic {
    TEST = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [SH_W-1:0]     sh_cnt_q, sh_cnt_d;
  logic [INV_W-1:0]    inv_cnt_q, inv_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                lock_q, lock_d;
  logic                slip_q, slip_d;

  logic                sh_ok;
  logic [SH_W-1:0]     sh_new;
  logic [INV_W-1:0]    inv_new;
  logic [WAIT_W-1:0]   wait_new;

  assign sh_ok    = head_i[1] ^ head_i[0];
  assign sh_new   = sh_cnt_q + SH_W'(1);
  assign inv_new  = inv_cnt_q + INV_W'(!sh_ok);
  assign wait_new = wait_cnt_q + WAIT_W'(1);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= TEST;
      sh_cnt_q   <= '0;
      inv_cnt_q  <= '0;
      wait_cnt_q <= '0;
      lock_q     <= 1'b0;
      slip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_cnt_q   <= sh_cnt_d;
      inv_cnt_q  <= inv_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      lock_q     <= lock_d;
      slip_q     <= slip_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sh_cnt_d   = sh_cnt_q;
    inv_cnt_d  = inv_cnt_q;
    wait_cnt_d = wait_cnt_q;
    lock_d     = lock_q;
    slip_d     = 1'b0;

    if (valid_i) begin
      unique case (state_q)
        TEST: begin
          // Slip decisions are checked before the window-end test so that a
          // 16th error landing on the last header of a window still unlocks.
          if (!sh_ok && (!lock_q || inv_new == INV_W'(SH_INV_MAX))) begin
            slip_d     = 1'b1;
            lock_d     = 1'b0;
            sh_cnt_d   = '0;
            inv_cnt_d  = '0;
            wait_cnt_d = '0;
            state_d    = (SLIP_WAIT == 0) ? TEST : WAIT;
          end else if (sh_new == SH_W'(SH_CNT_MAX)) begin
            // Clean window acquires lock; a tolerated dirty window (only
            // reachable while locked) simply keeps it.
            lock_d    = 1'b1;
            sh_cnt_d  = '0;
            inv_cnt_d = '0;
          end else begin
            sh_cnt_d  = sh_new;
            inv_cnt_d = inv_new;
          end
        end
        WAIT: begin
          if (wait_new == WAIT_W'(SLIP_WAIT)) begin
            wait_cnt_d = '0;
            state_d    = TEST;
          end else begin
            wait_cnt_d = wait_new;
          end
        end
        default: state_d = TEST;
      endcase
    end
  end

  assign slip_o = slip_q;
  assign lock_o = lock_q;

endmodule

// File: tb/tb_rx_block_sync.sv
// Self-checking bench for rx_block_sync: directed phases followed by a
// randomized run, all checked against a header-level reference model.
module tb_rx_block_sync;

  localparam int SH_CNT_MAX = 64;
  localparam int SH_INV_MAX = 16;
  localparam int SLIP_WAIT  = 2;

  logic       clk;
  logic       nreset;
  logic       valid_i;
  logic [1:0] head_i;
  logic       slip_o;
  logic       lock_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: headers seen in this window, bad ones among them,
  // headers still to discard after a slip, and the expected outputs.
  int m_seen    = 0;
  int m_bad     = 0;
  int m_discard = 0;
  bit m_lock    = 1'b0;
  bit m_slip    = 1'b0;

  rx_block_sync #(
    .SH_CNT_MAX(SH_CNT_MAX),
    .SH_INV_MAX(SH_INV_MAX),
    .SLIP_WAIT (SLIP_WAIT)
  ) dut (
    .clk    (clk),
    .nreset (nreset),
    .valid_i(valid_i),
    .head_i (head_i),
    .slip_o (slip_o),
    .lock_o (lock_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_seen = 0; m_bad = 0; m_discard = 0; m_lock = 1'b0; m_slip = 1'b0;
  endtask

  task automatic model_header(input bit v, input logic [1:0] h);
    bit good;
    m_slip = 1'b0;
    if (!v) return;
    if (m_discard > 0) begin
      m_discard--;
      return;
    end
    good = (h == 2'b01) || (h == 2'b10);
    m_seen++;
    if (!good) m_bad++;
    if (!good && (!m_lock || m_bad == SH_INV_MAX)) begin
      m_slip = 1'b1;
      m_lock = 1'b0;
      m_seen = 0;
      m_bad = 0;
      m_discard = SLIP_WAIT;
    end else if (m_seen == SH_CNT_MAX) begin
      m_lock = 1'b1;
      m_seen = 0;
      m_bad = 0;
    end
  endtask

  // Drive one cycle, then compare both outputs against the model.
  task automatic step(input bit v, input logic [1:0] h);
    @(negedge clk);
    valid_i = v;
    head_i  = h;
    @(posedge clk);
    model_header(v, h);
    #1;
    chk("lock", lock_o, m_lock);
    chk("slip", slip_o, m_slip);
  endtask

  function automatic logic [1:0] good_hdr(input int i);
    return (i % 2 == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
  endfunction

  initial begin
    bit bad_at[SH_CNT_MAX];
    int placed;
    int p;
    int bad_pct;

    nreset  = 1'b0;
    valid_i = 1'b0;
    head_i  = 2'b00;
    model_reset();

    // Reset held, then released.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_lock", lock_o, 1'b0);
    chk("reset_slip", slip_o, 1'b0);
    @(negedge clk);
    nreset = 1'b1;
    step(1'b0, 2'b00);
    chk("post_reset_lock", lock_o, 1'b0);

    // Acquire: 63 good headers leave lock low, the 64th raises it.
    for (int i = 0; i < SH_CNT_MAX - 1; i++) step(1'b1, good_hdr(i));
    chk("acq_63_lock", lock_o, 1'b0);
    step(1'b1, good_hdr(SH_CNT_MAX - 1));
    chk("acq_64_lock", lock_o, 1'b1);

    // Asynchronous reset mid-cycle while locked.
    @(negedge clk);
    valid_i = 1'b0;
    #2;
    nreset = 1'b0;
    #1;
    model_reset();
    chk("async_rst_lock", lock_o, 1'b0);
    chk("async_rst_slip", slip_o, 1'b0);
    @(negedge clk);
    nreset = 1'b1;

    // Unlocked error: slip pulse, two discarded bad headers, then relock.
    for (int i = 0; i < 10; i++) step(1'b1, good_hdr(i));
    step(1'b1, 2'b00);
    chk("unlk_slip_hi", slip_o, 1'b1);
    step(1'b1, 2'b11);
    chk("unlk_slip_lo", slip_o, 1'b0);
    step(1'b1, 2'b11);
    chk("unlk_wait_noslip", slip_o, 1'b0);
    for (int i = 0; i < SH_CNT_MAX; i++) step(1'b1, good_hdr(i));
    chk("relock", lock_o, 1'b1);

    // Locked window with SH_INV_MAX-1 errors keeps lock.
    for (int i = 0; i < SH_CNT_MAX; i++) bad_at[i] = 1'b0;
    placed = 0;
    while (placed < SH_INV_MAX - 1) begin
      p = $urandom_range(0, SH_CNT_MAX - 1);
      if (!bad_at[p]) begin bad_at[p] = 1'b1; placed++; end
    end
    for (int i = 0; i < SH_CNT_MAX; i++)
      step(1'b1, bad_at[i] ? bad_hdr() : good_hdr(i));
    chk("tol15_lock", lock_o, 1'b1);

    // Locked window with the 16th error on the last header.
    for (int i = 0; i < SH_CNT_MAX; i++) bad_at[i] = 1'b0;
    placed = 0;
    while (placed < SH_INV_MAX - 1) begin
      p = $urandom_range(0, SH_CNT_MAX - 2);
      if (!bad_at[p]) begin bad_at[p] = 1'b1; placed++; end
    end
    bad_at[SH_CNT_MAX - 1] = 1'b1;
    for (int i = 0; i < SH_CNT_MAX - 1; i++)
      step(1'b1, bad_at[i] ? bad_hdr() : good_hdr(i));
    chk("pre16_lock", lock_o, 1'b1);
    step(1'b1, 2'b00);
    chk("inv16_slip", slip_o, 1'b1);
    chk("inv16_lock", lock_o, 1'b0);

    // Discard the post-slip headers, then acquire with valid gaps.
    step(1'b1, 2'b01);
    step(1'b1, 2'b10);
    begin
      int got = 0;
      while (got < SH_CNT_MAX) begin
        if ($urandom_range(0, 2) == 0) step(1'b0, 2'b00);
        else begin
          step(1'b1, good_hdr(got));
          got++;
          if (got == SH_CNT_MAX - 1) chk("gap_63_lock", lock_o, 1'b0);
        end
      end
    end
    chk("gap_lock", lock_o, 1'b1);

    // Randomized phases with varying error density.
    for (int ph = 0; ph < 8; ph++) begin
      bad_pct = (ph % 4 == 0) ? 0 : (ph % 4 == 1) ? 2 : (ph % 4 == 2) ? 25 : 50;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 9) < 2) step(1'b0, 2'($urandom_range(0, 3)));
        else if ($urandom_range(0, 99) < bad_pct) step(1'b1, bad_hdr());
        else step(1'b1, good_hdr(i));
      end
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
